// File: rtl/burst_gen_pkg.sv
// Shared definitions for the burst generator and the detector-side blocks.
package burst_gen_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      GAP   = 2'd2
   } burst_state_t;

   localparam int BCD_MAX = 9;
   localparam int RUN_W   = 4;

   function automatic logic is_bcd(input logic [RUN_W-1:0] v);
      return v <= RUN_W'(BCD_MAX);
   endfunction

endpackage

// File: rtl/burst_gen_if.sv
// Request/serial-line bundle between a burst requester and burst_gen.
interface burst_gen_if;
   import burst_gen_pkg::*;

   logic             start;
   logic [RUN_W-1:0] count_bcd;
   logic             detection_out;
   logic             busy;
   logic             done;
   logic             err;
   logic [RUN_W-1:0] run_idx;

   modport master (
      output start, count_bcd,
      input  detection_out, busy, done, err, run_idx
   );

   modport slave (
      input  start, count_bcd,
      output detection_out, busy, done, err, run_idx
   );

endinterface

// File: rtl/burst_gen_bcd_down_counter.sv
// Loadable down-counter with zero flag; decrement saturates at zero.
module bcd_down_counter #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic         dec,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] value,
   output logic         zero
);

   always_ff @(posedge clk) begin
      if (rst) begin
         value <= '0;
      end else if (load) begin
         value <= load_val;
      end else if (dec && (value != '0)) begin
         value <= value - W'(1);
      end
   end

   assign zero = (value == '0);

endmodule

// File: rtl/burst_gen.sv
// Serial burst generator: N high cycles on detection_out, then a forced low gap.
//
// state | meaning
// IDLE  | waiting for start; done/err pulses shown here
// BURST | detection_out high, run_idx counting 1..N
// GAP   | detection_out low for GAP_LEN cycles before returning to IDLE
module burst_gen
   import burst_gen_pkg::*;
#(
   parameter int GAP_LEN = 1
) (
   input  logic       clk,
   input  logic       rst_a_p,
   burst_gen_if.slave bus
);

   localparam int GAP_W = $clog2(GAP_LEN + 1);
   localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(GAP_LEN);

   burst_state_t     state_q, state_d;
   logic             det_q, det_d;
   logic             busy_q;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic [RUN_W-1:0] idx_q, idx_d;

   logic             rem_load, rem_dec, rem_zero;
   logic [RUN_W-1:0] rem_value;
   logic             gap_load, gap_dec, gap_zero;
   logic [GAP_W-1:0] gap_value;
   logic             rem_last, gap_last;

   bcd_down_counter #(.W(RUN_W)) u_rem (
      .clk      (clk),
      .rst      (rst_a_p),
      .load     (rem_load),
      .dec      (rem_dec),
      .load_val (bus.count_bcd),
      .value    (rem_value),
      .zero     (rem_zero)
   );

   bcd_down_counter #(.W(GAP_W)) u_gap (
      .clk      (clk),
      .rst      (rst_a_p),
      .load     (gap_load),
      .dec      (gap_dec),
      .load_val (GAP_RELOAD),
      .value    (gap_value),
      .zero     (gap_zero)
   );

   // Terminal count at 1: the cycle showing the last high (or gap) cycle.
   assign rem_last = (rem_value == RUN_W'(1)) || rem_zero;
   assign gap_last = (gap_value == GAP_W'(1)) || gap_zero;

   always_ff @(posedge clk) begin
      if (rst_a_p) begin
         state_q <= IDLE;
         det_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         det_q   <= det_d;
         busy_q  <= (state_d != IDLE);
         done_q  <= done_d;
         err_q   <= err_d;
         idx_q   <= idx_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      det_d    = 1'b0;
      done_d   = 1'b0;
      err_d    = 1'b0;
      idx_d    = '0;
      rem_load = 1'b0;
      rem_dec  = 1'b0;
      gap_load = 1'b0;
      gap_dec  = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               if (!is_bcd(bus.count_bcd)) begin
                  err_d = 1'b1;
               end else if (bus.count_bcd == '0) begin
                  state_d  = GAP;
                  gap_load = 1'b1;
               end else begin
                  state_d  = BURST;
                  rem_load = 1'b1;
                  det_d    = 1'b1;
                  idx_d    = RUN_W'(1);
               end
            end
         end
         BURST: begin
            rem_dec = 1'b1;
            if (rem_last) begin
               state_d  = GAP;
               gap_load = 1'b1;
            end else begin
               det_d = 1'b1;
               idx_d = idx_q + RUN_W'(1);
            end
         end
         GAP: begin
            gap_dec = 1'b1;
            if (gap_last) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.detection_out = det_q;
   assign bus.busy          = busy_q;
   assign bus.done          = done_q;
   assign bus.err           = err_q;
   assign bus.run_idx       = idx_q;

endmodule

// File: tb/tb_burst_gen.sv
// Self-checking bench for burst_gen: vector table plus multi-cycle corner sequences.
module tb_burst_gen;

   localparam int G = 1;

   typedef struct packed {
      logic       det;
      logic       busy;
      logic       done;
      logic       err;
      logic [3:0] idx;
   } out_t;

   typedef struct {
      logic [3:0] cnt;
      int         exp_highs;
      bit         exp_err;
   } vec_t;

   localparam out_t IDLE_O = '{det: 1'b0, busy: 1'b0, done: 1'b0, err: 1'b0, idx: 4'd0};

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail = 0;
   out_t exp_q[$];

   burst_gen_if bus();

   burst_gen #(.GAP_LEN(G)) dut (
      .clk     (clk),
      .rst_a_p (rst),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   // Expected output stream for one accepted request, one entry per cycle.
   task automatic push_seq(input int highs, input bit is_err);
      out_t e;
      if (is_err) begin
         e = IDLE_O; e.err = 1'b1; exp_q.push_back(e);
         return;
      end
      for (int k = 1; k <= highs; k++) begin
         e = IDLE_O; e.det = 1'b1; e.busy = 1'b1; e.idx = 4'(k);
         exp_q.push_back(e);
      end
      for (int k = 0; k < G; k++) begin
         e = IDLE_O; e.busy = 1'b1; exp_q.push_back(e);
      end
      e = IDLE_O; e.done = 1'b1; exp_q.push_back(e);
   endtask

   task automatic check(input string name);
      out_t act, e;
      act = {bus.detection_out, bus.busy, bus.done, bus.err, bus.run_idx};
      e = IDLE_O;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      n_checks++;
      if (act !== e) begin
         n_fail++;
         $display("FAIL %s t=%0t: got det=%b busy=%b done=%b err=%b idx=%0d, want det=%b busy=%b done=%b err=%b idx=%0d",
                  name, $time, act.det, act.busy, act.done, act.err, act.idx,
                  e.det, e.busy, e.done, e.err, e.idx);
      end
   endtask

   task automatic tick(input string name);
      @(posedge clk);
      #1;
      check(name);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick(name);
      if (exp_q.size() != 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: timeout, %0d expected cycles left, want 0", name, exp_q.size());
         exp_q.delete();
      end
      tick({name, "_idle"});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time %0t exceeded, want finish earlier", $time);
      $fatal(1);
   end

   initial begin
      vec_t vecs[8];
      vecs[0] = '{cnt: 4'd3,  exp_highs: 3, exp_err: 1'b0};
      vecs[1] = '{cnt: 4'd1,  exp_highs: 1, exp_err: 1'b0};
      vecs[2] = '{cnt: 4'd0,  exp_highs: 0, exp_err: 1'b0};
      vecs[3] = '{cnt: 4'd9,  exp_highs: 9, exp_err: 1'b0};
      vecs[4] = '{cnt: 4'hC,  exp_highs: 0, exp_err: 1'b1};
      vecs[5] = '{cnt: 4'hA,  exp_highs: 0, exp_err: 1'b1};
      vecs[6] = '{cnt: 4'hF,  exp_highs: 0, exp_err: 1'b1};
      vecs[7] = '{cnt: 4'd7,  exp_highs: 7, exp_err: 1'b0};

      bus.start = 1'b0;
      bus.count_bcd = 4'd0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_hold");
      rst = 1'b0;
      tick("after_reset");

      foreach (vecs[v]) begin
         bus.start = 1'b1;
         bus.count_bcd = vecs[v].cnt;
         push_seq(vecs[v].exp_highs, vecs[v].exp_err);
         tick($sformatf("vec%0d_accept", v));
         bus.start = 1'b0;
         drain($sformatf("vec%0d", v));
      end

      // 9-burst, then a new start raised in the done cycle.
      bus.start = 1'b1;
      bus.count_bcd = 4'd9;
      push_seq(9, 1'b0);
      tick("b2b_first");
      bus.start = 1'b0;
      for (int i = 0; i < 40 && exp_q.size() > 1; i++) tick("b2b_first");
      tick("b2b_done");
      bus.start = 1'b1;
      bus.count_bcd = 4'd2;
      push_seq(2, 1'b0);
      tick("b2b_second");
      bus.start = 1'b0;
      drain("b2b_second");

      // Reset during the 2nd high cycle of a 5-burst.
      bus.start = 1'b1;
      bus.count_bcd = 4'd5;
      push_seq(5, 1'b0);
      tick("abort_hi1");
      bus.start = 1'b0;
      tick("abort_hi2");
      rst = 1'b1;
      exp_q.delete();
      tick("abort_reset");
      rst = 1'b0;
      bus.start = 1'b1;
      bus.count_bcd = 4'd2;
      push_seq(2, 1'b0);
      tick("abort_restart");
      bus.start = 1'b0;
      drain("abort_restart");

      // Reset and start together: reset wins.
      rst = 1'b1;
      bus.start = 1'b1;
      bus.count_bcd = 4'd3;
      tick("rst_vs_start");
      rst = 1'b0;
      bus.start = 1'b0;
      tick("rst_vs_start_idle");

      // start held high, count changing mid-burst: only the first value counts.
      bus.start = 1'b1;
      bus.count_bcd = 4'd4;
      push_seq(4, 1'b0);
      tick("hold_accept");
      for (int i = 0; i < 40 && exp_q.size() > 1; i++) begin
         bus.count_bcd = (i % 2 == 0) ? 4'd8 : 4'hC;
         tick("hold_burst");
      end
      bus.count_bcd = 4'd1;
      tick("hold_done");
      push_seq(1, 1'b0);
      tick("hold_reaccept");
      bus.start = 1'b0;
      drain("hold_second");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
